seg7_bcd_capture: RTL
=====================

Name: seg7_bcd_capture

Overview:
Reverse path of the BCD-to-7-segment decoder. The block samples the seven segment lines a..g of a display driver, synchronises them, and waits until the pattern has been stable for a set number of cycles. It then encodes the pattern back to a BCD digit with a one-cycle valid strobe. Uses: a loopback checker on the display path, and a front end for reading segment-driven displays.

Parameters:
STABLE_CYC, 4, consecutive equal synchronised samples required before a pattern is accepted (legal 1..255)
SEG_ACTIVE_LOW, 0, 1 = segment inputs are active-low and are inverted at the input

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
a  input  1  segment a (top)
b  input  1  segment b (upper right)
c  input  1  segment c (lower right)
d  input  1  segment d (bottom)
e  input  1  segment e (lower left)
f  input  1  segment f (upper left)
g  input  1  segment g (middle)
BCD  output  4  last accepted digit 0..9
BCD_VLD  output  1  one-cycle pulse when BCD takes a new accepted digit
BLANK  output  1  level; accepted pattern is all segments off
ERR  output  1  level; accepted pattern is not a legal glyph
ERR_CNT  output  8  saturating count of accepted illegal patterns

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - RST_N is asynchronous, active-low.
  - Reset values: BCD=0, BCD_VLD=0, BLANK=1, ERR=0, ERR_CNT=0.
  - Internal reset values: sync flops = 0, previous-sample p = 0, counter cnt = 0, accepted pattern acc = 7'b0, state = SETTLE.
- Input stage:
  - Vector {a,b,c,d,e,f,g} is inverted when SEG_ACTIVE_LOW=1.
  - It then passes through a 2-flop synchroniser; output s.
  - p <= s every cycle.
- FSM states: SETTLE, LOCK.
  - Any state, s != p: cnt <= 0, state <= SETTLE.
  - SETTLE, s == p, cnt < STABLE_CYC-1: cnt++.
  - SETTLE, s == p, cnt == STABLE_CYC-1: state <= LOCK; run the accept step.
  - LOCK, s == p: hold; cnt holds.
- Accept step (one cycle), evaluated only if s != acc; otherwise no output change:
  - acc <= s.
  - Legal glyph: BCD <= digit, BCD_VLD <= 1 for one cycle, BLANK <= 0, ERR <= 0.
  - Pattern 0000000: BLANK <= 1, ERR <= 0, BCD holds, no BCD_VLD.
  - Any other pattern: ERR <= 1, BLANK <= 0, BCD holds, no BCD_VLD, ERR_CNT++ (saturates at 255).
- Glyph table (abcdefg, 1 = lit):
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
- Latency: a pattern change presented before edge 0 and held gives BCD/BCD_VLD high after edge STABLE_CYC+2. With STABLE_CYC=4 that is edge 6.
- Glitches:
  - A glitch shorter than STABLE_CYC+1 samples restarts settling and is never accepted.
  - If the line returns to acc after a glitch, there is no BCD_VLD.
- Holding: the same pattern held indefinitely produces exactly one BCD_VLD.
- Reset mid-settle: all state is cleared immediately. The first pattern after reset is compared against acc=0, so a digit is reported even if it matches the pre-reset digit.

Optional Feature:
Macro SEG7_ALT_GLYPH_EN.
- Defined: the accept step also recognises these variants as legal, with identical outputs to the main glyphs:
  - 6 without top = 0011111
  - 7 with f lit = 1110010
  - 9 without bottom = 1110011
- Undefined: these three patterns are illegal; they set ERR and increment ERR_CNT.

Test Plan:
1. Reset, then drive 0000 digit pattern 1111110, STABLE_CYC=4 -> BCD=0, BCD_VLD pulses once after edge 6, BLANK falls to 0 with it.
2. Step through glyphs 1..9, each held 10 cycles -> nine BCD_VLD pulses, BCD=1..9 in order, ERR stays 0.
3. With 5 accepted, glitch to 1111111 for 3 cycles, then back to 5 -> no BCD_VLD, BCD stays 5, ERR_CNT unchanged.
4. Drive 1000001 held 10 cycles -> ERR=1, ERR_CNT=1, BCD holds previous value. Then drive 0110000 -> ERR=0, BCD=1, BCD_VLD pulse.
5. Drive 0000000 -> BLANK=1, no BCD_VLD. Drive 300 separate illegal acceptances -> ERR_CNT saturates at 255.
6. Assert RST_N low midway through settling on digit 8 -> outputs return to reset values asynchronously. After release with 8 still held, BCD=8 and BCD_VLD pulses after edge 6. With SEG7_ALT_GLYPH_EN defined, 0011111 gives BCD=6; undefined, it gives ERR=1.

Source files
------------

// File: rtl/seg7_bcd_capture_if.sv
// Segment-line capture bus: seven segment inputs a..g and the decoded digit/status outputs.
interface seg7_bcd_capture_if;
  logic       a, b, c, d, e, f, g;
  logic [3:0] BCD;
  logic       BCD_VLD;
  logic       BLANK;
  logic       ERR;
  logic [7:0] ERR_CNT;

  modport master (
    output a, b, c, d, e, f, g,
    input  BCD, BCD_VLD, BLANK, ERR, ERR_CNT
  );

  modport slave (
    input  a, b, c, d, e, f, g,
    output BCD, BCD_VLD, BLANK, ERR, ERR_CNT
  );
endinterface

// File: rtl/seg7_bcd_capture.sv
// Synchronises 7-segment lines, waits for a stable pattern and encodes it back to BCD.
// Optional macro SEG7_ALT_GLYPH_EN accepts alternate glyphs for 6, 7 and 9.
module seg7_bcd_capture #(
  parameter int unsigned STABLE_CYC     = 4,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input logic              CLK,
  input logic              RST_N,
  seg7_bcd_capture_if.slave bus
);

  typedef enum logic {SETTLE, LOCK} state_t;

  localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);

  logic [6:0] raw, seg_in, sync1, s, p, acc;
  logic [7:0] cnt, cnt_d;
  state_t     state, state_d;
  logic       accept;
  logic       dec_legal;
  logic [3:0] dec_digit;

  logic [3:0] bcd_q;
  logic       vld_q, blank_q, err_q;
  logic [7:0] errcnt_q;

  assign raw    = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g};
  assign seg_in = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      s     <= '0;
      p     <= '0;
    end else begin
      sync1 <= seg_in;
      s     <= sync1;
      p     <= s;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= SETTLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    if (s != p) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else if (state == SETTLE) begin
      if (cnt >= LAST) begin
        state_d = LOCK;
        accept  = 1'b1;
      end else begin
        cnt_d = cnt + 8'd1;
      end
    end
  end

  always_comb begin
    dec_legal = 1'b1;
    dec_digit = '0;
    case (s)
      7'b1111110: dec_digit = 4'd0;
      7'b0110000: dec_digit = 4'd1;
      7'b1101101: dec_digit = 4'd2;
      7'b1111001: dec_digit = 4'd3;
      7'b0110011: dec_digit = 4'd4;
      7'b1011011: dec_digit = 4'd5;
      7'b1011111: dec_digit = 4'd6;
      7'b1110000: dec_digit = 4'd7;
      7'b1111111: dec_digit = 4'd8;
      7'b1111011: dec_digit = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
      7'b0011111: dec_digit = 4'd6;
      7'b1110010: dec_digit = 4'd7;
      7'b1110011: dec_digit = 4'd9;
`endif
      default:    dec_legal = 1'b0;
    endcase
  end

  // Only a pattern that differs from the last accepted one changes the outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc      <= '0;
      bcd_q    <= '0;
      vld_q    <= 1'b0;
      blank_q  <= 1'b1;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      vld_q <= 1'b0;
      if (accept && (s != acc)) begin
        acc <= s;
        if (s == '0) begin
          blank_q <= 1'b1;
          err_q   <= 1'b0;
        end else if (dec_legal) begin
          bcd_q   <= dec_digit;
          vld_q   <= 1'b1;
          blank_q <= 1'b0;
          err_q   <= 1'b0;
        end else begin
          blank_q <= 1'b0;
          err_q   <= 1'b1;
          if (errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.BCD     = bcd_q;
  assign bus.BCD_VLD = vld_q;
  assign bus.BLANK   = blank_q;
  assign bus.ERR     = err_q;
  assign bus.ERR_CNT = errcnt_q;

endmodule
